mux_scan_sequencer: RTL

//   Upstream controller for the 7-to-1 channel mux (mux_7to1). Walks the mux select

---
 rtl/mux_scan_pkg.sv | 13 +
 rtl/mux_ch_pick.sv | 24 ++
 rtl/mux_scan_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared constants and state type for the mux scan sequencer and its channel picker.
package mux_scan_pkg;
  localparam int NUM_CH = 7;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] SEL_RESET = 3'd0;
endpackage

// File: rtl/mux_ch_pick.sv
// Combinational finder: lowest set mask bit strictly above i_cur, or lowest set bit when i_first=1.
module mux_ch_pick
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [SEL_W-1:0]  i_cur,
  input  logic              i_first,
  output logic [SEL_W-1:0]  o_next_sel,
  output logic              o_found
);

  // Scan from the top down so the last hit is the lowest qualifying channel.
  always_comb begin
    o_next_sel = SEL_RESET;
    o_found    = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_first || (SEL_W'(i) > i_cur))) begin
        o_next_sel = SEL_W'(i);
        o_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks the 7:1 mux select over enabled channels, samples each after a dwell window,
// and offers the assembled snapshot downstream.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [6:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  input  logic               mux_out,
  output logic               busy,
  output logic [6:0]         snap,
  output logic               snap_valid,
  input  logic               snap_ready,
  output logic [1:0]         o_dbg_state
);

  state_t              r_state;
  logic [NUM_CH-1:0]   r_mask;
  logic [DWELL_W-1:0]  r_dwell;
  logic [DWELL_W-1:0]  r_cnt;
  logic [SEL_W-1:0]    r_sel;
  logic [NUM_CH-1:0]   r_acc;
  logic [NUM_CH-1:0]   r_snap;
  logic                r_snap_valid;
  logic                r_busy;

  logic [SEL_W-1:0]    w_first_sel;
  logic                w_first_found;
  logic [SEL_W-1:0]    w_next_sel;
  logic                w_next_found;
  logic [NUM_CH-1:0]   w_acc_merged;

  mux_ch_pick u_pick_first (
    .i_mask     (ch_mask),
    .i_cur      (SEL_RESET),
    .i_first    (1'b1),
    .o_next_sel (w_first_sel),
    .o_found    (w_first_found)
  );

  mux_ch_pick u_pick_next (
    .i_mask     (r_mask),
    .i_cur      (r_sel),
    .i_first    (1'b0),
    .o_next_sel (w_next_sel),
    .o_found    (w_next_found)
  );

  always_comb begin
    w_acc_merged        = r_acc;
    w_acc_merged[r_sel] = mux_out;
  end

  // Snapshot handshake: snap_valid stays high with snap stable until a cycle with
  // snap_valid & snap_ready; that edge is the transfer. snap_ready is ignored otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_mask       <= '0;
      r_dwell      <= '0;
      r_cnt        <= '0;
      r_sel        <= SEL_RESET;
      r_acc        <= '0;
      r_snap       <= '0;
      r_snap_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && w_first_found) begin
            r_mask  <= ch_mask;
            r_dwell <= dwell;
            r_cnt   <= dwell;
            r_acc   <= '0;
            r_sel   <= w_first_sel;
            r_busy  <= 1'b1;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (r_cnt == '0) begin
            r_acc <= w_acc_merged;
            if (w_next_found) begin
              r_sel <= w_next_sel;
              r_cnt <= r_dwell;
            end else begin
              // sel stays on the last channel throughout HOLD
              r_snap       <= w_acc_merged;
              r_snap_valid <= 1'b1;
              r_state      <= HOLD;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (snap_ready) begin
            r_snap_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_sel        <= SEL_RESET;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sel         = r_sel;
  assign busy        = r_busy;
  assign snap        = r_snap;
  assign snap_valid  = r_snap_valid;
  assign o_dbg_state = r_state;

endmodule
